seq_signed_multiplier: RTL and testbench
========================================

# seq_signed_multiplier

Parametrised sequential add-shift multiplier with integrated datapath and control. It generalises the fixed 8-bit multiplier controller to `WIDTH` bits and uses a single loop counter in place of unrolled per-bit states. It adds a signed/unsigned mode, busy/done status and a run-release handshake. It sits between the switch/button interface and the hex display driver and produces a `2*WIDTH`-bit product.

## Interface
Parameters:
- `WIDTH`, default 8: operand width; legal range 2..32.

Ports:
- `clk`  in  1: system clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high; one clock domain only.
- `run`  in  1: level request to start a multiply; sampled only in IDLE.
- `clear_load`  in  1: in IDLE, clears A and X and loads B from `sw_in`; ignored in every other state.
- `signed_mode`  in  1: 1 = two's-complement operands, 0 = unsigned; sampled and held at start.
- `sw_in`  in  WIDTH: operand bus. Multiplier on `clear_load`; multiplicand S on start.
- `a_out`  out  WIDTH: accumulator A (product high half).
- `b_out`  out  WIDTH: register B (multiplier, then product low half).
- `x_out`  out  1: sign/carry extension bit X.
- `product`  out  2*WIDTH: equals {A, B}.
- `busy`  out  1: high in ADD and SHIFT.
- `done`  out  1: high in DONE.

## Operation
- Registers: A, B, S (WIDTH bits each), X (1 bit), mode flag M, counter `cnt` of $clog2(WIDTH) bits.
- States and transitions:
  - IDLE → ADD when `run`=1.
  - ADD → SHIFT always.
  - SHIFT → ADD when `cnt` < WIDTH-1; SHIFT → DONE when `cnt` = WIDTH-1.
  - DONE → IDLE when `run`=0.
- IDLE:
  - `clear_load`=1 sets A=0, X=0 and B=`sw_in`.
  - If `run`=1 on the same edge, `run` wins: A=0, X=0, S=`sw_in`, M=`signed_mode`, `cnt`=0, and B keeps its value.
- ADD: if B[0]=0, there is no change (no-op cycle). If B[0]=1, compute in WIDTH+1 bits:
  - Signed mode: operands are sign-extended. The result is A−S when `cnt`=WIDTH-1 and A+S otherwise.
  - Unsigned mode: operands are zero-extended and the operation is always A+S.
  - The result's low WIDTH bits go to A and its MSB goes to X.
- SHIFT: {X,A,B} shifts right by 1 and `cnt` increments.
  - A[WIDTH-1] takes X, B[WIDTH-1] takes A[0], and B[0] is discarded.
  - X is kept in signed mode (arithmetic shift) and cleared in unsigned mode.
- DONE: all registers hold; `product` is valid. If `run` stays high, the block stays in DONE, so exactly one multiply runs per run press.
- Arithmetic:
  - Signed result range is −2^(2W−2)+… up to +2^(2W−2). For example, (−2^(W−1))² = 2^(2W−2) is representable.
  - Unsigned maximum is (2^W−1)² with no overflow.
- Back-to-back multiply: after DONE→IDLE, the product stays in A/B until the next `clear_load` or start. A start only replaces A, X and S, so B (the previous product low half) becomes the next multiplier.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE.
  - A, B, S, X, M, `cnt` = 0.
  - `busy`=0, `done`=0, `product`=0.
- Reset mid-multiply aborts immediately; no partial result is retained.
- Latency: with the start edge at cycle 0, `busy`=1 for cycles 1..2·WIDTH and `done`=1 from cycle 2·WIDTH+1. The latency is fixed and independent of operand values.
- `done` stays high until the first edge that sees `run`=0; it drops in the following cycle.
- Changes to `sw_in`, `signed_mode` and `clear_load` while busy do not affect the result.
- All outputs are registered or decoded directly from state; there is no combinational path from inputs to outputs.

## Test plan
- Reset check: assert `reset` asynchronously mid-cycle during a multiply → all outputs 0 at once and state IDLE; with `reset` low and `run`=0, the block stays idle.
- Signed, WIDTH=8: `clear_load` with `sw_in`=0x07, then `run` with `sw_in`=0xFD (−3) and `signed_mode`=1 → `product`=0xFFEB (−21). `done` rises exactly 17 cycles after the start edge; `busy` is high for 16 cycles.
- Signed boundaries, WIDTH=8:
  - 0x80×0x80 → 0x4000.
  - 0x80×0x7F → 0xC080.
  - 0xFF×0xFF → 0x0001.
- Unsigned, WIDTH=8: 0xFD×0x07 → 0x06EB; 0xFF×0xFF → 0xFE01.
- Handshake and back-to-back:
  - Hold `run` high through DONE for 10 cycles → no restart.
  - Release `run`, then press again with `sw_in`=0x02, following a first product of 0x0003 → 0x0006.
  - `clear_load` pulsed while busy → ignored.
- Parametrisation: WIDTH=4 and WIDTH=16 with randomized operands in both modes (≥1000 each) → matches the reference model; latency is 2·WIDTH+1 cycles.

Source files
------------

// File: rtl/seq_signed_multiplier.sv
// Sequential add-shift multiplier, WIDTH-bit signed/unsigned operands, 2*WIDTH-bit product {A,B}.
// Fixed latency: busy for 2*WIDTH cycles after the start edge, done until run is released; no backpressure.
module seq_signed_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 clear_load,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     sw_in,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic                 x_out,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             x_q, m_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   a_ext, s_ext, sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = ADD;
      ADD:     state_nxt = SHIFT;
      SHIFT:   state_nxt = (cnt_q == LAST) ? DONE : ADD;
      DONE:    if (!run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The final multiplier bit carries negative weight in two's complement, hence the subtract.
  always_comb begin
    a_ext = m_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
    s_ext = m_q ? {s_q[WIDTH-1], s_q} : {1'b0, s_q};
    if (m_q && (cnt_q == LAST)) sum = a_ext - s_ext;
    else                        sum = a_ext + s_ext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      x_q   <= 1'b0;
      m_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            a_q   <= '0;
            x_q   <= 1'b0;
            s_q   <= sw_in;
            m_q   <= signed_mode;
            cnt_q <= '0;
          end else if (clear_load) begin
            a_q <= '0;
            x_q <= 1'b0;
            b_q <= sw_in;
          end
        end
        ADD: begin
          if (b_q[0]) begin
            a_q <= sum[WIDTH-1:0];
            x_q <= sum[WIDTH];
          end
        end
        SHIFT: begin
          a_q   <= {x_q, a_q[WIDTH-1:1]};
          b_q   <= {a_q[0], b_q[WIDTH-1:1]};
          x_q   <= m_q ? x_q : 1'b0;
          cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign a_out   = a_q;
  assign b_out   = b_q;
  assign x_out   = x_q;
  assign product = {a_q, b_q};
  assign busy    = (state == ADD) || (state == SHIFT);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Bench for seq_signed_multiplier at WIDTH 8, 4 and 16 against a cycle-level arithmetic model.
module tb_seq_signed_multiplier;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        run_s [NI];
  logic        cl_s  [NI];
  logic        sm_s  [NI];
  logic [31:0] sw_s  [NI];

  logic [7:0]  a8, b8;   logic [15:0] p8;  logic x8, bz8, dn8;
  logic [3:0]  a4, b4;   logic [7:0]  p4;  logic x4, bz4, dn4;
  logic [15:0] a16, b16; logic [31:0] p16; logic x16, bz16, dn16;

  seq_signed_multiplier #(.WIDTH(8)) u_w8 (
    .clk(clk), .reset(reset), .run(run_s[0]), .clear_load(cl_s[0]), .signed_mode(sm_s[0]),
    .sw_in(sw_s[0][7:0]), .a_out(a8), .b_out(b8), .x_out(x8), .product(p8), .busy(bz8), .done(dn8));
  seq_signed_multiplier #(.WIDTH(4)) u_w4 (
    .clk(clk), .reset(reset), .run(run_s[1]), .clear_load(cl_s[1]), .signed_mode(sm_s[1]),
    .sw_in(sw_s[1][3:0]), .a_out(a4), .b_out(b4), .x_out(x4), .product(p4), .busy(bz4), .done(dn4));
  seq_signed_multiplier #(.WIDTH(16)) u_w16 (
    .clk(clk), .reset(reset), .run(run_s[2]), .clear_load(cl_s[2]), .signed_mode(sm_s[2]),
    .sw_in(sw_s[2][15:0]), .a_out(a16), .b_out(b16), .x_out(x16), .product(p16), .busy(bz16), .done(dn16));

  logic [63:0] prod_w [NI];
  logic [63:0] a_w    [NI];
  logic [63:0] b_w    [NI];
  logic        x_w    [NI];
  logic        busy_w [NI];
  logic        done_w [NI];

  assign prod_w[0] = {48'd0, p8};  assign a_w[0] = {56'd0, a8};  assign b_w[0] = {56'd0, b8};
  assign prod_w[1] = {56'd0, p4};  assign a_w[1] = {60'd0, a4};  assign b_w[1] = {60'd0, b4};
  assign prod_w[2] = {32'd0, p16}; assign a_w[2] = {48'd0, a16}; assign b_w[2] = {48'd0, b16};
  assign x_w[0] = x8;   assign busy_w[0] = bz8;  assign done_w[0] = dn8;
  assign x_w[1] = x4;   assign busy_w[1] = bz4;  assign done_w[1] = dn4;
  assign x_w[2] = x16;  assign busy_w[2] = bz16; assign done_w[2] = dn16;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  function automatic int wof(input int k);
    case (k)
      0:       return 8;
      1:       return 4;
      default: return 16;
    endcase
  endfunction

  function automatic logic [63:0] msk(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Plain integer product of the two operands, reduced to 2*w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] mr, input logic [31:0] md,
                                          input bit sm);
    longint a, b, p;
    a = longint'({32'd0, md} & msk(w));
    b = longint'({32'd0, mr} & msk(w));
    if (sm && a[w-1]) a = a - (longint'(1) << w);
    if (sm && b[w-1]) b = b - (longint'(1) << w);
    p = a * b;
    return 64'(p) & msk(2 * w);
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (width %0d): got 0x%0h, expected 0x%0h", nm, wof(k), act, exp);
  endtask

  // Model: phase 0 idle, 1..2w busy, 2w+1 done; m_prod is the visible {A,B} outside busy.
  int          ph     [NI];
  logic [63:0] m_prod [NI];
  logic [63:0] m_pend [NI];
  bit          xk     [NI];

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < NI; k++) begin
      int w;
      w = wof(k);
      if (reset) begin
        ph[k] = 0; m_prod[k] = 64'd0; m_pend[k] = 64'd0; xk[k] = 1'b1;
      end else if (ph[k] == 0) begin
        if (run_s[k]) begin
          ph[k] = 1;
          m_pend[k] = ref_mul(w, m_prod[k][31:0], sw_s[k], sm_s[k]);
        end else if (cl_s[k]) begin
          m_prod[k] = {32'd0, sw_s[k]} & msk(w);
          xk[k] = 1'b1;
        end
      end else if (ph[k] <= 2 * w) begin
        ph[k]++;
        if (ph[k] == 2 * w + 1) begin
          m_prod[k] = m_pend[k];
          xk[k] = 1'b0;
        end
      end else if (!run_s[k]) begin
        ph[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      for (int k = 0; k < NI; k++) begin
        int w;
        bit mb;
        w  = wof(k);
        mb = (ph[k] >= 1) && (ph[k] <= 2 * w);
        chk("busy", k, 64'(busy_w[k]), 64'(mb));
        chk("done", k, 64'(done_w[k]), 64'(ph[k] == 2 * w + 1));
        if (!mb) begin
          chk("product", k, prod_w[k], m_prod[k]);
          chk("a_out", k, a_w[k], (m_prod[k] >> w) & msk(w));
          chk("b_out", k, b_w[k], m_prod[k] & msk(w));
          if (xk[k]) chk("x_out", k, 64'(x_w[k]), 64'd0);
        end
      end
    end
  end

  task automatic do_mult(input int k, input bit do_clr, input logic [31:0] mr, input logic [31:0] md,
                         input bit sm, input bit lit, input logic [63:0] lit_exp, input int hold,
                         input bit junk, input bit cl_with_run);
    int w, cyc, nb;
    bit seen;
    w = wof(k); cyc = 0; nb = 0; seen = 1'b0;
    @(negedge clk);
    if (do_clr) begin
      cl_s[k] = 1'b1; sw_s[k] = mr;
      @(negedge clk);
      cl_s[k] = 1'b0;
    end
    run_s[k] = 1'b1; sw_s[k] = md; sm_s[k] = sm; cl_s[k] = cl_with_run;
    @(posedge clk);
    #1 cl_s[k] = 1'b0;
    while (!seen && cyc < 4 * w + 8) begin
      @(negedge clk);
      cyc++;
      if (busy_w[k]) nb++;
      if (done_w[k]) seen = 1'b1;
      else if (junk) begin
        sw_s[k] = $urandom;
        sm_s[k] = 1'($urandom_range(0, 1));
        cl_s[k] = 1'($urandom_range(0, 1));
      end
    end
    cl_s[k] = 1'b0;
    chk("done_seen", k, 64'(seen), 64'd1);
    chk("latency", k, 64'(cyc), 64'(2 * w + 1));
    chk("busy_cycles", k, 64'(nb), 64'(2 * w));
    if (lit) chk("product_lit", k, prod_w[k], lit_exp);
    repeat (hold) @(negedge clk);
    chk("done_held", k, 64'(done_w[k]), 64'd1);
    run_s[k] = 1'b0;
    @(negedge clk);
    chk("done_drop", k, 64'(done_w[k]), 64'd0);
    if (lit) chk("product_kept", k, prod_w[k], lit_exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      run_s[k] = 1'b0; cl_s[k] = 1'b0; sm_s[k] = 1'b0; sw_s[k] = 32'd0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < NI; k++) begin
      chk("reset_product", k, prod_w[k], 64'd0);
      chk("reset_busy", k, 64'(busy_w[k]), 64'd0);
      chk("reset_done", k, 64'(done_w[k]), 64'd0);
      chk("reset_x", k, 64'(x_w[k]), 64'd0);
    end
    chk_en = 1'b1;

    do_mult(0, 1, 32'h07, 32'hFD, 1, 1, 64'hFFEB, 0, 1, 0);
    do_mult(0, 1, 32'h80, 32'h80, 1, 1, 64'h4000, 0, 0, 0);
    do_mult(0, 1, 32'h7F, 32'h80, 1, 1, 64'hC080, 0, 0, 0);
    do_mult(0, 1, 32'hFF, 32'hFF, 1, 1, 64'h0001, 0, 0, 0);
    do_mult(0, 1, 32'hFD, 32'h07, 1, 1, 64'hFFEB, 0, 0, 0);
    do_mult(0, 1, 32'h07, 32'hFD, 0, 1, 64'h06EB, 0, 0, 0);
    do_mult(0, 1, 32'hFF, 32'hFF, 0, 1, 64'hFE01, 0, 0, 0);
    do_mult(0, 1, 32'h01, 32'h03, 0, 1, 64'h0003, 10, 0, 0);
    do_mult(0, 0, 32'h00, 32'h02, 0, 1, 64'h0006, 0, 1, 0);
    // clear_load on the start edge must lose to run: multiplier stays 6.
    do_mult(0, 0, 32'h00, 32'h05, 0, 1, 64'h001E, 0, 0, 1);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    cl_s[0] = 1'b1; sw_s[0] = 32'h55;
    @(negedge clk);
    cl_s[0] = 1'b0; run_s[0] = 1'b1; sw_s[0] = 32'h33; sm_s[0] = 1'b1;
    repeat (6) @(negedge clk);
    run_s[0] = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_product", 0, prod_w[0], 64'd0);
    chk("abort_a", 0, a_w[0], 64'd0);
    chk("abort_b", 0, b_w[0], 64'd0);
    chk("abort_x", 0, 64'(x_w[0]), 64'd0);
    chk("abort_busy", 0, 64'(busy_w[0]), 64'd0);
    chk("abort_done", 0, 64'(done_w[0]), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", 0, 64'(busy_w[0]), 64'd0);
    chk("idle_product", 0, prod_w[0], 64'd0);

    for (int k = 0; k < NI; k++) begin
      int n;
      n = (k == 0) ? 200 : 1000;
      for (int i = 0; i < n; i++) begin
        do_mult(k, ($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 1)),
                0, 64'd0, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
      end
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
